// File: rtl/pwm_dac_multi.sv
// Multi-channel PWM DAC: shared period counter, double-buffered period/duty/mode, edge or center aligned.
// Optional fractional duty dither when PWM_DITHER_EN is defined.
module pwm_dac_multi #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int FRAC     = 4,
`ifdef PWM_DITHER_EN
    localparam int DW      = WIDTH + FRAC
`else
    localparam int DW      = WIDTH + 0 * FRAC
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   mode,
    input  logic [WIDTH-1:0]       period,
    input  logic [CHANNELS*DW-1:0] duty,
    input  logic                   load,
    output logic                   load_pending,
    output logic                   period_start,
    output logic [CHANNELS-1:0]    pwm_out
);

    logic [WIDTH-1:0]       cnt;
    logic                   dir;
    logic [WIDTH-1:0]       p_act, p_sh;
    logic                   mode_act, mode_sh;
    logic [CHANNELS*DW-1:0] duty_sh;
    logic [WIDTH:0]         d_eff    [CHANNELS];
    logic [WIDTH:0]         d_eff_nx [CHANNELS];
    logic                   boundary;
    logic [WIDTH-1:0]       src_p;
    logic                   src_mode;
    logic [CHANNELS*DW-1:0] src_duty;
`ifdef PWM_DITHER_EN
    logic [FRAC-1:0]        acc      [CHANNELS];
    logic [FRAC-1:0]        acc_nx   [CHANNELS];
    logic [FRAC:0]          acc_sum  [CHANNELS];
`endif

    // A load in the boundary cycle bypasses the shadow and goes straight to active.
    always_comb begin
        if (!enable)
            boundary = 1'b1;
        else if (mode_act)
            boundary = (p_act == '0) ||
                       ((cnt == WIDTH'(1)) && (dir || (p_act == WIDTH'(1))));
        else
            boundary = (cnt == p_act);
        src_p    = load ? period : p_sh;
        src_mode = load ? mode   : mode_sh;
        src_duty = load ? duty   : duty_sh;
        for (int i = 0; i < CHANNELS; i++) begin
`ifdef PWM_DITHER_EN
            acc_sum[i]  = {1'b0, acc[i]} + {1'b0, src_duty[i*DW +: FRAC]};
            acc_nx[i]   = enable ? acc_sum[i][FRAC-1:0] : acc[i];
            d_eff_nx[i] = {1'b0, src_duty[i*DW+FRAC +: WIDTH]}
                          + (WIDTH+1)'(enable & acc_sum[i][FRAC]);
`else
            d_eff_nx[i] = {1'b0, src_duty[i*DW +: WIDTH]};
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            dir          <= 1'b0;
            p_act        <= '0;
            p_sh         <= '0;
            mode_act     <= 1'b0;
            mode_sh      <= 1'b0;
            duty_sh      <= '0;
            load_pending <= 1'b0;
            period_start <= 1'b0;
            pwm_out      <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                d_eff[i] <= '0;
`ifdef PWM_DITHER_EN
                acc[i]   <= '0;
`endif
            end
        end else begin
            if (load) begin
                p_sh    <= period;
                mode_sh <= mode;
                duty_sh <= duty;
            end
            period_start <= enable && (cnt == '0);
            for (int i = 0; i < CHANNELS; i++)
                pwm_out[i] <= enable && ({1'b0, cnt} < d_eff[i]);
            if (boundary) begin
                cnt          <= '0;
                dir          <= 1'b0;
                p_act        <= src_p;
                mode_act     <= src_mode;
                load_pending <= 1'b0;
                d_eff        <= d_eff_nx;
`ifdef PWM_DITHER_EN
                acc          <= acc_nx;
`endif
            end else begin
                if (load)
                    load_pending <= 1'b1;
                if (!mode_act) begin
                    cnt <= cnt + 1'b1;
                end else if (dir) begin
                    cnt <= cnt - 1'b1;
                end else if (cnt == p_act) begin
                    cnt <= cnt - 1'b1;
                    dir <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/pwm_dac_multi.md
Name: pwm_dac_multi

Overview:
Multi-channel PWM DAC and successor to the single-channel PWM DAC. CHANNELS outputs share one period counter; each channel has its own duty value. Period, duty and mode are double-buffered and take effect only at a period boundary, so an update never produces a glitched period. Supports edge-aligned and center-aligned modes; an optional dither feature adds fractional duty resolution. Sits between the NCO/sample path and the off-chip RC filters.

Parameters:
WIDTH, 16, bit width of the period counter, period and integer duty values
CHANNELS, 4, number of PWM outputs (≥1)
FRAC, 4, fractional duty bits per channel (used only when PWM_DITHER_EN is defined)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
enable  input  1  1 = run counter; 0 = hold counter at 0, outputs low
mode  input  1  0 = edge-aligned, 1 = center-aligned (shadowed)
period  input  WIDTH  period value P (shadowed)
duty  input  CHANNELS*DW  channel i duty in bits [i*DW +: DW]; DW = WIDTH, or WIDTH+FRAC with dither (shadowed)
load  input  1  1-cycle strobe: capture mode/period/duty into shadow registers
load_pending  output  1  shadow holds values not yet transferred to active
period_start  output  1  1-cycle pulse in the cycle after cnt == 0 at the start of a period
pwm_out  output  CHANNELS  registered PWM outputs

Behaviour:
- Reset (async, rst=1): cnt=0, dir=up, shadow and active period/duty/mode=0, dither accumulators=0, pwm_out=0, load_pending=0, period_start=0.
- load=1: shadow registers capture all inputs on that edge; load_pending←1.
- Boundary = last cycle of a period:
  - edge mode: cnt == P_act.
  - center mode: dir=down and cnt == 1, or P_act == 0.
- At a boundary, active ← shadow and load_pending ← 0. If load coincides with the boundary, the new input values go straight to active (bypass) and load_pending stays 0.
- Edge mode: cnt counts 0,1,…,P_act, then wraps to 0. Period = P_act+1 clocks.
- Center mode: cnt counts 0 up to P_act, then P_act−1 down to 1, then 0. Period = 2·P_act clocks (1 clock if P_act=0).
  - dir flips to down when cnt reaches P_act, and back to up when the counter wraps to 0.
- Switching mode at a boundary restarts at cnt=0, dir=up.
- Compare, per channel i: pwm_out[i] ← (cnt < D_eff[i]). The compare is done at WIDTH+1 bits, so there is no overflow. Output lags the counter by 1 clock.
- Duty limits:
  - D=0: constant low.
  - D > P_act: constant high for the whole period (100%). There is no wrap glitch at the period boundary.
  - P_act=0: cnt stays 0, every cycle is a boundary, and the output is high iff D_eff>0.
- period_start ← (cnt == 0 and enable), registered. It pulses once per period; with P_act=0 it is high every cycle.
- enable=0:
  - cnt forced to 0, dir=up, pwm_out forced low, period_start=0.
  - Every cycle counts as a boundary, so pending loads transfer immediately.
- enable 0→1: the first period starts at cnt=0 with the current active values.
- Reset mid-period aborts it immediately. A pending load is lost.

Optional Feature:
Macro PWM_DITHER_EN.
- Defined:
  - Each duty field is WIDTH+FRAC bits: the integer part is the upper WIDTH bits, the fraction f is the lower FRAC bits.
  - Each channel has a FRAC-bit accumulator. At each boundary: acc ← acc + f_next, where f_next is the fraction being made active.
  - The carry-out sets D_eff = integer + 1 for the next period; no carry gives D_eff = integer.
  - Result: the average duty resolves 2^-FRAC LSB.
  - Accumulators reset to 0 and do not update while enable=0.
- Not defined: duty fields are WIDTH bits, D_eff = duty, no accumulators, and the FRAC parameter is unused.

Test Plan:
1. WIDTH=8, edge mode, P=9, duty ch0=3, ch1=0, ch2=10, ch3=255, then load and enable → period 10 clocks; ch0 high for 3 of 10 clocks; ch1 constant 0; ch2 and ch3 constant 1; period_start every 10 clocks.
2. Running P=9, duty=3; load duty=7 at cnt=4 → load_pending=1 until the boundary at cnt=9; next period high for 7 clocks; the current period stays at 3.
3. Center mode, P=4, duty=2 → cnt sequence 0,1,2,3,4,3,2,1 repeating; pwm_out (1-clk lag) pattern 1,1,0,0,0,0,0,1 per 8-clock period; output symmetric.
4. load asserted in the exact boundary cycle with P=5 → the next period uses P=5 immediately; load_pending never rises.
5. P=0, duty=1 → pwm_out constant 1 and period_start constant 1. enable=0 → pwm_out=0, cnt=0, and load applies the next cycle with load_pending returning to 0.
6. Dither, FRAC=4, P=9, duty=3 + 4/16 → over 16 periods exactly 4 periods high for 4 clocks and 12 high for 3 (52 high clocks out of 160). Assert rst mid-period → all outputs 0 asynchronously; restart matches from cnt=0.
